// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with write bypass and busy scoreboard
module regfile_mp #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int AW     = $clog2(NREG),
    parameter int NUM_RD = 2,
    parameter int BYPASS = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_RD*AW-1:0]   rd_addr,
    output logic [NUM_RD*XLEN-1:0] rd_data,
    output logic [NUM_RD-1:0]      rd_busy,
    input  logic [1:0]             wr_en,
    input  logic [2*AW-1:0]        wr_addr,
    input  logic [2*XLEN-1:0]      wr_data,
    input  logic                   issue_en,
    input  logic [AW-1:0]          issue_addr,
    input  logic                   flush,
    output logic                   busy_any
);
    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic [AW-1:0]   w0_addr;
    logic [AW-1:0]   w1_addr;
    logic [XLEN-1:0] w0_data;
    logic [XLEN-1:0] w1_data;
    logic            w0_go;
    logic            w1_go;

    assign w0_addr = wr_addr[AW-1:0];
    assign w1_addr = wr_addr[2*AW-1:AW];
    assign w0_data = wr_data[XLEN-1:0];
    assign w1_data = wr_data[2*XLEN-1:XLEN];
    assign w0_go   = wr_en[0] && w0_addr != '0;
    assign w1_go   = wr_en[1] && w1_addr != '0;

    // Register storage; W1 is applied last so it wins on an address collision
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            if (w0_go) regs[w0_addr] <= w0_data;
            if (w1_go) regs[w1_addr] <= w1_data;
        end
    end

    // Busy next state: flush, then issue, then write-clear, else hold; x0 never busy
    assign busy_nxt[0] = 1'b0;
    for (genvar i = 1; i < NREG; i++) begin : g_busy
        assign busy_nxt[i] = flush ? 1'b0 :
                             (issue_en && issue_addr == AW'(i)) ? 1'b1 :
                             ((w0_go && w0_addr == AW'(i)) || (w1_go && w1_addr == AW'(i))) ? 1'b0 :
                             busy[i];
    end

    // Scoreboard register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) busy <= '0;
        else busy <= busy_nxt;
    end

    assign busy_any = reset && |busy;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0] a;
        logic          hit0;
        logic          hit1;
        assign a    = rd_addr[k*AW +: AW];
        assign hit0 = BYPASS != 0 && w0_go && w0_addr == a;
        assign hit1 = BYPASS != 0 && w1_go && w1_addr == a;
        assign rd_data[k*XLEN +: XLEN] = (!reset || a == '0) ? '0 :
                                         hit1 ? w1_data :
                                         hit0 ? w0_data : regs[a];
        assign rd_busy[k] = reset && busy[a];
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks of regfile_mp with a bypassing 2-port and a registered 3-port build
module tb_regfile_mp;
    logic        clk = 0;
    logic        reset = 0;
    logic [9:0]  a_rd_addr = '0;
    logic [63:0] a_rd_data;
    logic [1:0]  a_rd_busy;
    logic        a_busy_any;
    logic [14:0] b_rd_addr = '0;
    logic [95:0] b_rd_data;
    logic [2:0]  b_rd_busy;
    logic        b_busy_any;
    logic [1:0]  wr_en = '0;
    logic [9:0]  wr_addr = '0;
    logic [63:0] wr_data = '0;
    logic        issue_en = 0;
    logic [4:0]  issue_addr = '0;
    logic        flush = 0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    regfile_mp #(.NUM_RD(2), .BYPASS(1)) dut_a (
        .clk(clk), .reset(reset), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .issue_en(issue_en),
        .issue_addr(issue_addr), .flush(flush), .busy_any(a_busy_any)
    );

    regfile_mp #(.NUM_RD(3), .BYPASS(0)) dut_b (
        .clk(clk), .reset(reset), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .issue_en(issue_en),
        .issue_addr(issue_addr), .flush(flush), .busy_any(b_busy_any)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        wr_en = '0;
        issue_en = 0;
        flush = 0;
        #1;
    endtask

    initial begin
        wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'h0, 32'hDEADBEEF}; a_rd_addr = {5'd0, 5'd3};
        #1;
        chk("rst_forced_rd", a_rd_data[31:0], 32'h0);
        chk("rst_busy_any", a_busy_any, 0);
        wr_en = '0;
        @(negedge clk);
        reset = 1;
        for (int i = 0; i < 32; i++) begin
            a_rd_addr = {5'(31 - i), 5'(i)};
            #1;
            chk("rst_rd0", a_rd_data[31:0], 32'h0);
            chk("rst_rd1", a_rd_data[63:32], 32'h0);
            chk("rst_busy", a_rd_busy, 0);
        end
        chk("rst_any", a_busy_any, 0);

        wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'h0, 32'hDEADBEEF};
        a_rd_addr = {5'd0, 5'd3}; b_rd_addr = {10'd0, 5'd3};
        #1;
        chk("byp1_same", a_rd_data[31:0], 32'hDEADBEEF);
        chk("byp0_same", b_rd_data[31:0], 32'h0);
        tick();
        chk("byp1_next", a_rd_data[31:0], 32'hDEADBEEF);
        chk("byp0_next", b_rd_data[31:0], 32'hDEADBEEF);

        wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'h22, 32'h11};
        a_rd_addr = {5'd0, 5'd7}; b_rd_addr = {10'd0, 5'd7};
        #1;
        chk("coll_byp", a_rd_data[31:0], 32'h22);
        tick();
        chk("coll_a", a_rd_data[31:0], 32'h22);
        chk("coll_b", b_rd_data[31:0], 32'h22);

        wr_en = 2'b11; wr_addr = {5'd9, 5'd8}; wr_data = {32'h44, 32'h33};
        tick();
        a_rd_addr = {5'd9, 5'd8};
        #1;
        chk("dual_x8", a_rd_data[31:0], 32'h33);
        chk("dual_x9", a_rd_data[63:32], 32'h44);

        wr_en = 2'b01; wr_addr = {5'd0, 5'd0}; wr_data = {32'h0, 32'hFFFFFFFF};
        issue_en = 1; issue_addr = 5'd0; a_rd_addr = {5'd0, 5'd0};
        #1;
        chk("x0_byp", a_rd_data[31:0], 32'h0);
        tick();
        chk("x0_rd", a_rd_data[31:0], 32'h0);
        chk("x0_busy", a_rd_busy, 0);
        chk("x0_any", a_busy_any, 0);

        issue_en = 1; issue_addr = 5'd10;
        tick();
        a_rd_addr = {5'd0, 5'd10};
        #1;
        chk("iss_busy", a_rd_busy, 2'b01);
        chk("iss_any", a_busy_any, 1);
        wr_en = 2'b10; wr_addr = {5'd10, 5'd0}; wr_data = {32'h55, 32'h0};
        #1;
        chk("wclr_same", a_rd_busy, 2'b01);
        tick();
        chk("wclr_busy", a_rd_busy, 0);
        chk("wclr_any", a_busy_any, 0);
        chk("wclr_data", a_rd_data[31:0], 32'h55);
        issue_en = 1; issue_addr = 5'd10; wr_en = 2'b01; wr_addr = {5'd0, 5'd10}; wr_data = {32'h0, 32'h66};
        tick();
        chk("iss_beats_wr", a_rd_busy, 2'b01);
        chk("iss_wr_data", a_rd_data[31:0], 32'h66);

        issue_en = 1; issue_addr = 5'd4;
        tick();
        issue_en = 1; issue_addr = 5'd6;
        tick();
        issue_en = 1; issue_addr = 5'd12;
        tick();
        b_rd_addr = {5'd12, 5'd6, 5'd4}; a_rd_addr = {5'd6, 5'd4};
        #1;
        chk("b_busy3", b_rd_busy, 3'b111);
        chk("a_busy2", a_rd_busy, 2'b11);
        chk("b_any", b_busy_any, 1);
        flush = 1; issue_en = 1; issue_addr = 5'd13;
        tick();
        chk("fl_b_busy", b_rd_busy, 0);
        chk("fl_b_any", b_busy_any, 0);
        chk("fl_a_any", a_busy_any, 0);
        a_rd_addr = {5'd10, 5'd13};
        #1;
        chk("fl_x13_x10", a_rd_busy, 0);

        wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'h1234};
        tick();
        a_rd_addr = {5'd3, 5'd5};
        #1;
        chk("x5_stored", a_rd_data[31:0], 32'h1234);
        reset = 0;
        #1;
        chk("mid_rst_x5", a_rd_data[31:0], 32'h0);
        reset = 1;
        #1;
        chk("post_rst_x5", a_rd_data[31:0], 32'h0);
        chk("post_rst_x3", a_rd_data[63:32], 32'h0);
        wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'hABCD};
        tick();
        chk("post_rst_wr", a_rd_data[31:0], 32'hABCD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port integer register file for the pipelined core. It replaces the fixed 2-read/1-write file with configurable read ports, two write ports (EX-forwarded ALU result and MEM/load result), and a selectable write-to-read bypass. It also holds a per-register busy scoreboard that the decode stage uses to detect RAW hazards on long-latency results. It sits between decode (reads, issue) and writeback (writes).

Parameters:
XLEN, 32, data width of each register
NREG, 32, number of registers; power of two, at least 2
AW, $clog2(NREG), address width (derived, not overridden)
NUM_RD, 2, number of read ports, 1..4
BYPASS, 1, 1 = same-cycle write data is forwarded to matching reads; 0 = reads see registered contents only

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
rd_addr  input  NUM_RD*AW  read addresses; port k uses bits [k*AW +: AW]
rd_data  output  NUM_RD*XLEN  read data; port k uses bits [k*XLEN +: XLEN]
rd_busy  output  NUM_RD  scoreboard busy bit of each addressed register
wr_en  input  2  write enables; bit 0 = port W0, bit 1 = port W1
wr_addr  input  2*AW  write addresses; W0 in [AW-1:0], W1 in [2*AW-1:AW]
wr_data  input  2*XLEN  write data; W0 in the low XLEN bits, W1 in the high XLEN bits
issue_en  input  1  marks issue_addr busy (an instruction with a pending result was issued)
issue_addr  input  AW  destination register of the issued instruction
flush  input  1  synchronous clear of all busy bits (pipeline flush)
busy_any  output  1  OR of all busy bits

Behaviour:
- Reset (reset=0, asynchronous): all registers are 0 and all busy bits are 0. While reset is low, rd_data, rd_busy and busy_any are forced to 0, regardless of address or bypass.
- Register 0 always reads 0 and is never busy. Writes to address 0 are discarded. issue_en with issue_addr=0 is ignored.
- Writes: on the rising edge, each enabled port with a nonzero address loads its data. If W0 and W1 target the same address in the same cycle, W1 wins. Writes to distinct addresses both take effect.
- Reads are combinational with zero latency:
  - BYPASS=1: if an enabled write port targets the read address (nonzero), rd_data returns that port's wr_data in the same cycle. W1 has priority over W0, matching write priority.
  - BYPASS=0: rd_data returns the stored value; the new value is visible from the cycle after the edge.
- Busy scoreboard, per register r≠0, next state at the rising edge, in priority order:
  1. flush=1: busy cleared for all r. flush overrides same-cycle issue.
  2. issue_en=1 and issue_addr=r: busy set. Issue beats a same-cycle write-clear to the same r, because the new producer is outstanding.
  3. Any enabled write to r: busy cleared.
  4. Otherwise: busy holds.
- rd_busy[k] is the stored busy bit of rd_addr[k]. It is not bypassed; a clearing write is reflected the cycle after the edge.
- busy_any is combinational from the stored busy bits.
- Address width: AW bits. Addresses are always in range because NREG is a power of two.
- Reset asserted mid-operation: state clears immediately, and a write in flight at that edge is lost. After release, the first rising edge behaves normally.
- No X propagation: every output is defined for all input combinations once out of reset.

Test Plan:
- Reset then read all 32 addresses on both ports -> rd_data=0, rd_busy=0, busy_any=0. Assert reset mid-stream after writing x5=0x1234 -> x5 reads 0 immediately.
- W0 writes x3=0xDEADBEEF and reads port0=x3 in the same cycle: BYPASS=1 -> 0xDEADBEEF that cycle; BYPASS=0 -> 0 that cycle, 0xDEADBEEF the next.
- W0 x7=0x11 and W1 x7=0x22 in the same cycle -> x7 reads 0x22 afterwards, and the bypassed read that cycle is 0x22. W0 x8=0x33 with W1 x9=0x44 -> both stored.
- Write x0=0xFFFFFFFF and issue x0 -> x0 reads 0, rd_busy=0.
- Issue x10 -> next cycle rd_busy=1 and busy_any=1. W1 writes x10 -> busy clears next cycle. Issue x10 together with a W0 write to x10 -> busy stays 1.
- Issue x4, x6, x12 on successive cycles, then flush together with issue x13 -> all busy bits 0 and busy_any=0 next cycle. NUM_RD=3 build reads x4/x6/x12 busy correctly before the flush.
